// File: rtl/viterbi_trans_scanner_pkg.sv
// Shared widths, limits and FSM encoding for the Viterbi transition scanner.
// COST_MAX is the saturation value for accumulated negative-log costs.
package viterbi_trans_scanner_pkg;

    localparam int unsigned p_size      = 32;
    localparam int unsigned POS_num     = 11;
    localparam int unsigned POS_num_bit = 4;

    localparam logic [p_size-1:0]      COST_MAX = '1;
    localparam logic [POS_num_bit-1:0] POS_LAST = POS_num_bit'(POS_num - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/viterbi_min_acc.sv
// Saturating score+transition adder feeding a keep-minimum (best, backpointer) pair.
// The *_next outputs already include the current query, so a caller can latch the final result on the last query.
module viterbi_min_acc
    import viterbi_trans_scanner_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_first,
    input  logic [POS_num_bit-1:0] i_p,
    input  logic [p_size-1:0]      i_score,
    input  logic [p_size-1:0]      i_trans,
    output logic [p_size-1:0]      o_best_next,
    output logic [POS_num_bit-1:0] o_bp_next
);

    logic [p_size-1:0]      r_best;
    logic [POS_num_bit-1:0] r_bp;
    logic [p_size:0]        w_sum;
    logic [p_size-1:0]      w_sat;
    logic                   w_take;

    assign w_sum  = {1'b0, i_score} + {1'b0, i_trans};
    assign w_sat  = w_sum[p_size] ? COST_MAX : w_sum[p_size-1:0];
    // Strict compare: on a tie the earlier (lower) previous POS is kept.
    assign w_take = i_first || (w_sat < r_best);

    assign o_best_next = w_take ? w_sat : r_best;
    assign o_bp_next   = w_take ? i_p   : r_bp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= '0;
            r_bp   <= '0;
        end else if (i_en) begin
            r_best <= o_best_next;
            r_bp   <= o_bp_next;
        end
    end

endmodule

// File: rtl/viterbi_trans_scanner.sv
// Query-side master of the transition lookup: for each current POS it scans all previous POS
// and emits the minimum accumulated cost with its backpointer.
module viterbi_trans_scanner
    import viterbi_trans_scanner_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [POS_num_bit-1:0] prev_pos_q,
    output logic [POS_num_bit-1:0] cur_pos_q,
    input  logic [p_size-1:0]      trans_p,
    input  logic [POS_num_bit-1:0] prev_echo,
    input  logic [POS_num_bit-1:0] cur_echo,
    output logic [POS_num_bit-1:0] score_addr,
    input  logic [p_size-1:0]      score_data,
    output logic                   res_valid,
    output logic [POS_num_bit-1:0] res_cur,
    output logic [POS_num_bit-1:0] res_prev,
    output logic [p_size-1:0]      res_cost,
    output logic                   echo_err
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [POS_num_bit-1:0] r_p;
    logic [POS_num_bit-1:0] r_c;
    logic                   r_echo_err;
    logic                   r_res_valid;
    logic [POS_num_bit-1:0] r_res_cur;
    logic [POS_num_bit-1:0] r_res_prev;
    logic [p_size-1:0]      r_res_cost;
    logic                   w_scan;
    logic                   w_p_last;
    logic [p_size-1:0]      w_best_next;
    logic [POS_num_bit-1:0] w_bp_next;

    assign w_scan   = (r_state == ST_SCAN);
    assign w_p_last = (r_p == POS_LAST);

    viterbi_min_acc u_min_acc (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_scan),
        .i_first     (r_p == '0),
        .i_p         (r_p),
        .i_score     (score_data),
        .i_trans     (trans_p),
        .o_best_next (w_best_next),
        .o_bp_next   (w_bp_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_SCAN;
            ST_SCAN:  if (w_p_last) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = (r_c == POS_LAST) ? ST_DONE : ST_SCAN;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Result registers are loaded on the last query so they are valid during WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p         <= '0;
            r_c         <= '0;
            r_echo_err  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_cur   <= '0;
            r_res_prev  <= '0;
            r_res_cost  <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_p        <= '0;
                        r_c        <= '0;
                        r_echo_err <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if ((prev_echo != r_p) || (cur_echo != r_c)) r_echo_err <= 1'b1;
                    if (w_p_last) begin
                        r_res_valid <= 1'b1;
                        r_res_cur   <= r_c;
                        r_res_prev  <= w_bp_next;
                        r_res_cost  <= w_best_next;
                    end else begin
                        r_p <= r_p + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_c != POS_LAST) begin
                        r_c <= r_c + 1'b1;
                        r_p <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign prev_pos_q = r_p;
    assign cur_pos_q  = r_c;
    assign score_addr = r_p;
    assign res_valid  = r_res_valid;
    assign res_cur    = r_res_cur;
    assign res_prev   = r_res_prev;
    assign res_cost   = r_res_cost;
    assign echo_err   = r_echo_err;

endmodule

// File: tb/tb_viterbi_trans_scanner.sv
// Directed bench for viterbi_trans_scanner with a behavioural transition lookup and score memory.
module tb_viterbi_trans_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  prev_pos_q;
    logic [3:0]  cur_pos_q;
    logic [31:0] trans_p;
    logic [3:0]  prev_echo;
    logic [3:0]  cur_echo;
    logic [3:0]  score_addr;
    logic [31:0] score_data;
    logic        res_valid;
    logic [3:0]  res_cur;
    logic [3:0]  res_prev;
    logic [31:0] res_cost;
    logic        echo_err;

    int          total;
    int          bad;
    int          mode;
    bit          echo_fault;
    logic [31:0] scores [0:10];

    viterbi_trans_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .prev_pos_q (prev_pos_q),
        .cur_pos_q  (cur_pos_q),
        .trans_p    (trans_p),
        .prev_echo  (prev_echo),
        .cur_echo   (cur_echo),
        .score_addr (score_addr),
        .score_data (score_data),
        .res_valid  (res_valid),
        .res_cur    (res_cur),
        .res_prev   (res_prev),
        .res_cost   (res_cost),
        .echo_err   (echo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lookup model: mode 1 -> 10*p+5, mode 2 -> 0, mode 3 -> 3, mode 4 -> 0x20 for p==3 else 1.
    always_comb begin
        case (mode)
            1:       trans_p = 32'd10 * {28'd0, prev_pos_q} + 32'd5;
            3:       trans_p = 32'd3;
            4:       trans_p = (prev_pos_q == 4'd3) ? 32'h20 : 32'd1;
            default: trans_p = 32'd0;
        endcase
        prev_echo  = (echo_fault && prev_pos_q == 4'd4) ? 4'd0 : prev_pos_q;
        cur_echo   = cur_pos_q;
        score_data = (score_addr <= 4'd10) ? scores[score_addr] : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one full step; every result is expected to carry exp_prev/exp_cost.
    task automatic run_scan(input string name, input logic [31:0] exp_prev,
                            input logic [31:0] exp_cost, input logic exp_err);
        int n_res;
        int done_cyc;
        int first_cyc;
        int cyc;
        n_res = 0; done_cyc = -1; first_cyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check({name, "_busy_c1"}, {31'd0, busy}, 32'd1);
        check({name, "_err_c1"}, {31'd0, echo_err}, 32'd0);
        for (int k = 0; k < 150; k++) begin
            if (res_valid) begin
                if (n_res == 0) first_cyc = cyc;
                check({name, "_res_cur"}, {28'd0, res_cur}, n_res);
                check({name, "_res_prev"}, {28'd0, res_prev}, exp_prev);
                check({name, "_res_cost"}, res_cost, exp_cost);
                n_res++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_n_res"}, n_res, 32'd11);
        check({name, "_first_res_cycle"}, first_cyc, 32'd12);
        check({name, "_done_cycle"}, done_cyc, 32'd133);
        check({name, "_echo_err"}, {31'd0, echo_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({name, "_done_after"}, {31'd0, done}, 32'd0);
        check({name, "_err_held"}, {31'd0, echo_err}, {31'd0, exp_err});
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_prev_q"}, {28'd0, prev_pos_q}, 32'd0);
        check({name, "_cur_q"}, {28'd0, cur_pos_q}, 32'd0);
        check({name, "_addr"}, {28'd0, score_addr}, 32'd0);
        check({name, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({name, "_res_cur"}, {28'd0, res_cur}, 32'd0);
        check({name, "_res_prev"}, {28'd0, res_prev}, 32'd0);
        check({name, "_res_cost"}, res_cost, 32'd0);
        check({name, "_echo_err"}, {31'd0, echo_err}, 32'd0);
    endtask

    initial begin
        int n_res;
        int last_cur;
        bit done_seen;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; mode = 1; echo_fault = 1'b0;
        for (int i = 0; i < 11; i++) scores[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Scores 0, trans 10p+5: p=0 wins with cost 5.
        run_scan("t1", 32'd0, 32'd5, 1'b0);

        // Score 100-p, trans 0: p=10 wins with cost 90.
        mode = 2;
        for (int i = 0; i < 11; i++) scores[i] = 32'd100 - i;
        run_scan("t2", 32'd10, 32'd90, 1'b0);

        // Full tie keeps p=0.
        mode = 3;
        for (int i = 0; i < 11; i++) scores[i] = 32'd7;
        run_scan("t3", 32'd0, 32'd10, 1'b0);

        // Every sum overflows: saturate, tie at all-ones keeps p=0.
        mode = 4;
        for (int i = 0; i < 11; i++) scores[i] = 32'hFFFF_FFFF;
        scores[3] = 32'hFFFF_FFF0;
        run_scan("t4", 32'd0, 32'hFFFF_FFFF, 1'b0);

        // Echo fault sets the sticky flag; the next start clears it.
        mode = 1;
        for (int i = 0; i < 11; i++) scores[i] = 32'd0;
        echo_fault = 1'b1;
        run_scan("t5_fault", 32'd0, 32'd5, 1'b1);
        echo_fault = 1'b0;
        run_scan("t5_clear", 32'd0, 32'd5, 1'b0);

        // Mid-scan start is ignored; reset at cycle 50 aborts the scan.
        echo_fault = 1'b1;
        n_res = 0; last_cur = -1; done_seen = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 50; cyc++) begin
            if (res_valid) begin
                n_res++;
                last_cur = int'(res_cur);
            end
            if (done) done_seen = 1'b1;
            if (cyc == 20) start = 1'b1;
            if (cyc == 21) start = 1'b0;
            @(posedge clk); #1;
        end
        check("t6_n_res_before_rst", n_res, 32'd4);
        check("t6_last_cur", last_cur, 32'd3);
        check("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        check("t6_err_before_rst", {31'd0, echo_err}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("t6_async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("t6_rst_held");
        rst = 1'b0;
        echo_fault = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || res_valid) done_seen = 1'b1;
        end
        check("t6_no_done", {31'd0, done_seen}, 32'd0);
        check("t6_idle", {31'd0, busy}, 32'd0);
        run_scan("t6_fresh", 32'd0, 32'd5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/viterbi_trans_scanner.md
Name: viterbi_trans_scanner

Overview:
- Query-side master for the transition-probability lookup. It drives (previous POS, current POS) pairs, consumes the returned 32-bit transition cost and echoes, and produces one Viterbi step.
- For every current POS c it computes best[c] = min over p of (score[p] + trans[p][c]) and the arg-min backpointer.
- Sits between the per-word score memory and the transition lookup, feeding the backpointer/score writer.
- All costs are unsigned negative-log values: smaller is better.

Parameters:
- p_size, 32, width of score and transition cost.
- POS_num, 11, number of POS tags.
- POS_num_bit, 4, width of a POS index (2^POS_num_bit >= POS_num).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when all POS_num results have been emitted.
- prev_pos_q  out  POS_num_bit  previous-POS query to the lookup (registered).
- cur_pos_q  out  POS_num_bit  current-POS query to the lookup (registered).
- trans_p  in  p_size  transition cost for (prev_pos_q, cur_pos_q); combinational, valid the same cycle.
- prev_echo  in  POS_num_bit  previous-POS echo returned by the lookup.
- cur_echo  in  POS_num_bit  current-POS echo returned by the lookup.
- score_addr  out  POS_num_bit  read address into the previous-word score memory; equals prev_pos_q.
- score_data  in  p_size  score[score_addr]; combinational, same cycle.
- res_valid  out  1  result strobe.
- res_cur  out  POS_num_bit  current POS of the result.
- res_prev  out  POS_num_bit  best previous POS (backpointer).
- res_cost  out  p_size  best accumulated cost.
- echo_err  out  1  sticky mismatch flag; cleared on accepted start.

Behaviour:
- Reset (async, any state, including mid-scan):
  - state = IDLE; all outputs = 0.
  - Internal best = 0 and counters = 0.
  - No result or done is emitted for an interrupted scan.
- FSM states: IDLE, SCAN, WRITE, DONE.
- IDLE:
  - On start=1: p=0, c=0, echo_err=0; go to SCAN.
  - Otherwise stay in IDLE.
- SCAN, one query per cycle, with prev_pos_q=p and cur_pos_q=c:
  - sum = score_data + trans_p, computed at p_size+1 bits and saturated to all-ones on overflow.
  - If p==0 or sum < best (strict): best = sum, bp = p. Ties keep the lower p.
  - If prev_echo != p or cur_echo != c: set echo_err (stays set until the next accepted start).
  - If p == POS_num-1: go to WRITE. Otherwise p = p+1.
- WRITE, one cycle:
  - res_valid = 1, res_cur = c, res_prev = bp, res_cost = best.
  - If c == POS_num-1: go to DONE. Otherwise c = c+1, p = 0, go to SCAN.
- DONE: done = 1 for one cycle, then IDLE.
- Result outputs hold their last value when res_valid = 0.
- Timing (start sampled at edge 0):
  - SCAN for c=0 occupies cycles 1..POS_num; WRITE is cycle POS_num+1.
  - Total SCAN+WRITE = POS_num*(POS_num+1) cycles = 132 for the defaults.
  - done is high in cycle 133.
- busy = (state != IDLE).
- start is ignored in SCAN, WRITE and DONE (no restart, no error).
- Queries never exceed POS_num-1; counter values POS_num..2^POS_num_bit-1 are never driven.

Decomposition:
- Shared package: p_size, POS_num, POS_num_bit, the FSM state encoding, and COST_MAX (all-ones of p_size).
- One natural sub-module: viterbi_min_acc. It holds the saturating adder and the compare/keep-min register pair (best, bp) with a clear-on-p==0 input.
- Integration: the controller FSM and counters stay in the top.

Test Plan:
- All scores 0, trans[p][c] = 10*p + 5 -> eleven res_valid pulses, res_cur 0..10, res_prev = 0, res_cost = 5; done exactly 133 cycles after start; echo_err = 0.
- score[p] = 100 - p, trans = 0 -> every result res_prev = 10, res_cost = 90.
- score all 7, trans all 3 (full tie) -> res_prev = 0, res_cost = 10 for all c.
- score[3] = 0xFFFFFFF0, trans[3][*] = 0x20, all others 0xFFFFFFFF -> res_cost = 0xFFFFFFFF, res_prev = 0; no wrap to a small value.
- Model the lookup with prev_echo forced to 0 when p == 4 -> echo_err = 1 from that cycle and held after done; next start clears it to 0.
- Assert rst at cycle 50 of a scan; re-pulse start in SCAN before that -> the mid-scan start has no effect; after reset all outputs = 0, state IDLE, no done; a fresh start completes normally in 133 cycles.
